// File: rtl/accelerator_pkg.sv
// accelerator_pkg: shared types and constants for the vector accelerator.
//   vseq_state_t   - vector_sequencer FSM states
//   vseq_wb_t      - write-beat bundle carried through the arithmetic-latency pipe
//   vseq_raw_beats - unclamped count of 32-bit beats for a given vl/vsew
package accelerator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } vseq_state_t;

  localparam int VSEQ_BEAT_BYTES = 4;
  localparam int VSEQ_MAX_BEATS  = 16;

  typedef struct packed {
    logic       wr;
    logic [1:0] cycle_count;
    logic [1:0] reg_offset;
    logic [1:0] etw;
  } vseq_wb_t;

  // Beats needed to cover vl elements of 2^vsew bytes, rounded up to whole beats.
  // vsew = 3 is illegal and never issues, so its (wrapped) result is irrelevant.
  function automatic logic [7:0] vseq_raw_beats(input logic [4:0] vl, input logic [1:0] vsew);
    logic [7:0] bytes;
    bytes = {3'b000, vl} << vsew;
    return (bytes + 8'(VSEQ_BEAT_BYTES - 1)) >> $clog2(VSEQ_BEAT_BYTES);
  endfunction

endpackage

// File: rtl/vseq_wb_delay.sv
// vseq_wb_delay: reset-clearing shift register that delays the write-beat
// bundle so the register-file strobe lines up with the arithmetic result.
//   clk, reset : clock and asynchronous active-high clear
//   in_data    : bundle entering at the issue stage
//   out_data   : bundle DEPTH cycles later (DEPTH = 0 is a wire)
module vseq_wb_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    assign out_data = in_data;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
      end else begin
        stage_reg[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
      end
    end

    assign out_data = stage_reg[DEPTH-1];
  end

endmodule

// File: rtl/vector_sequencer.sv
// vector_sequencer: multi-beat issue controller between the APU handshake and
// the vector datapath. Takes one instruction at a time, walks its 32-bit beats,
// delays the register write strobe by ARITH_LAT and returns one apu_rvalid.
//   apu_req/apu_gnt/apu_rvalid        : CPU offload handshake
//   op_multicycle, op_vreg_write, vl, vsew : instruction info, sampled at accept
//   busy, cycle_count, reg_offset, last_beat : issue-side beat control
//   vec_reg_write, wb_cycle_count, wb_reg_offset, elements_to_write : write side
//   seq_error                         : flags an illegal vsew alongside apu_rvalid
module vector_sequencer
  import accelerator_pkg::*;
#(
  parameter int ARITH_LAT = 1,              // 0..3
  parameter int MAX_BEATS = VSEQ_MAX_BEATS  // beat counter is 4 bits: at most 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       apu_req,
  output logic       apu_gnt,
  output logic       apu_rvalid,
  input  logic       op_multicycle,
  input  logic       op_vreg_write,
  input  logic [4:0] vl,
  input  logic [1:0] vsew,
  output logic       busy,
  output logic [1:0] cycle_count,
  output logic [1:0] reg_offset,
  output logic       last_beat,
  output logic       vec_reg_write,
  output logic [1:0] wb_cycle_count,
  output logic [1:0] wb_reg_offset,
  output logic [1:0] elements_to_write,
  output logic       seq_error
);

  localparam logic [1:0] DRAIN_LAST  = (ARITH_LAT > 0) ? 2'(ARITH_LAT - 1) : 2'd0;
  localparam logic [4:0] MAX_BEATS_V = 5'(MAX_BEATS);

  vseq_state_t state_reg, state_next;
  logic [3:0]  beat_reg, beat_next;
  logic [1:0]  drain_reg, drain_next;
  logic [4:0]  vl_reg;
  logic [1:0]  vsew_reg;
  logic        vreg_write_reg;
  logic [4:0]  beats_reg;
  logic        clamped_reg;

  logic        accept;
  logic [7:0]  raw_beats;
  logic        acc_clamped;
  logic [4:0]  acc_beats;
  logic        acc_no_beats;
  logic [2:0]  epb;
  logic [5:0]  done_elems;
  logic [5:0]  remaining;
  logic        is_last;
  logic [1:0]  etw;
  vseq_wb_t    wb_in, wb_out;

  assign raw_beats    = vseq_raw_beats(vl, vsew);
  assign acc_clamped  = raw_beats > 8'(MAX_BEATS);
  assign acc_beats    = acc_clamped ? MAX_BEATS_V : raw_beats[4:0];
  assign acc_no_beats = (acc_beats == 5'd0) || !op_multicycle || (vsew == 2'd3);
  assign accept       = (state_reg == IDLE) && apu_req && !reset;

  // Per-beat element count: a full beat holds 4 >> vsew elements; only the
  // final beat of an unclamped op can be partial.
  assign epb        = 3'd4 >> vsew_reg;
  assign done_elems = {2'b00, beat_reg} * {3'b000, epb};
  assign remaining  = {1'b0, vl_reg} - done_elems;
  assign is_last    = ({1'b0, beat_reg} == (beats_reg - 5'd1));
  assign etw        = (is_last && !clamped_reg) ? 2'(remaining - 6'd1) : 2'(epb - 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      beat_reg       <= 4'd0;
      drain_reg      <= 2'd0;
      vl_reg         <= 5'd0;
      vsew_reg       <= 2'd0;
      vreg_write_reg <= 1'b0;
      beats_reg      <= 5'd0;
      clamped_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      drain_reg <= drain_next;
      if (accept) begin
        vl_reg         <= vl;
        vsew_reg       <= vsew;
        vreg_write_reg <= op_vreg_write;
        beats_reg      <= acc_beats;
        clamped_reg    <= acc_clamped;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    beat_next   = beat_reg;
    drain_next  = drain_reg;
    apu_gnt     = 1'b0;
    apu_rvalid  = 1'b0;
    seq_error   = 1'b0;
    cycle_count = 2'd0;
    reg_offset  = 2'd0;
    last_beat   = 1'b0;
    wb_in       = '0;
    unique case (state_reg)
      IDLE: begin
        apu_gnt = !reset;
        if (accept) begin
          beat_next  = 4'd0;
          state_next = acc_no_beats ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        cycle_count = beat_reg[1:0];
        reg_offset  = beat_reg[3:2];
        last_beat   = is_last;
        // Non-writing ops still walk their beats but push an empty bundle,
        // so the write side stays all-zero.
        if (vreg_write_reg) begin
          wb_in.wr          = 1'b1;
          wb_in.cycle_count = beat_reg[1:0];
          wb_in.reg_offset  = beat_reg[3:2];
          wb_in.etw         = etw;
        end
        if (is_last) begin
          beat_next  = 4'd0;
          drain_next = 2'd0;
          state_next = (ARITH_LAT > 0) ? DRAIN : RESP;
        end else begin
          beat_next = beat_reg + 4'd1;
        end
      end
      DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          drain_next = 2'd0;
          state_next = RESP;
        end else begin
          drain_next = drain_reg + 2'd1;
        end
      end
      RESP: begin
        apu_rvalid = 1'b1;
        seq_error  = (vsew_reg == 2'd3);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  vseq_wb_delay #(
    .DEPTH(ARITH_LAT),
    .WIDTH($bits(vseq_wb_t))
  ) u_wb_delay (
    .clk     (clk),
    .reset   (reset),
    .in_data (wb_in),
    .out_data(wb_out)
  );

  assign busy              = (state_reg != IDLE);
  assign vec_reg_write     = wb_out.wr;
  assign wb_cycle_count    = wb_out.cycle_count;
  assign wb_reg_offset     = wb_out.reg_offset;
  assign elements_to_write = wb_out.etw;

endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer: three sequencers (ARITH_LAT = 0, 1, 2), each with its own
// driver, transaction-level reference model and scoreboard monitor.
`timescale 1ns/1ps
module tb_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle k is the interval following posedge k; sampled on the falling edge.
  int pe = 0;
  always @(posedge clk) pe <= pe + 1;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  task automatic chk(input int lat, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL L=%0d %s at cycle %0d: got %0d, expected %0d", lat, name, pe, act, exp);
    end
  endtask

  typedef struct {
    int cyc;
    int cc;
    int ro;
    int etw;
  } wexp_t;

  typedef struct {
    int cyc;
    int err;
  } rexp_t;

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int L = gi;

    logic       rst, req, mc, vw;
    logic [4:0] vl_i;
    logic [1:0] vsew_i;
    logic       gnt, rvalid, busy, last, vrw, err;
    logic [1:0] cc, ro, wcc, wro, etw;

    wexp_t wq[$];
    rexp_t rq[$];
    int    next_free = 0;

    vector_sequencer #(.ARITH_LAT(L), .MAX_BEATS(16)) u_dut (
      .clk              (clk),
      .reset            (rst),
      .apu_req          (req),
      .apu_gnt          (gnt),
      .apu_rvalid       (rvalid),
      .op_multicycle    (mc),
      .op_vreg_write    (vw),
      .vl               (vl_i),
      .vsew             (vsew_i),
      .busy             (busy),
      .cycle_count      (cc),
      .reg_offset       (ro),
      .last_beat        (last),
      .vec_reg_write    (vrw),
      .wb_cycle_count   (wcc),
      .wb_reg_offset    (wro),
      .elements_to_write(etw),
      .seq_error        (err)
    );

    // Reference model: an accepted op in cycle k covers vl elements of
    // 2^vsew bytes, four bytes per beat, at most 16 beats. Beat b issues in
    // cycle k+1+b and is written L cycles later; the response follows the
    // last write slot, or comes immediately when nothing issues.
    task automatic model_accept(input int k, input int v, input int s, input bit m, input bit w);
      int size, epb, n, e, rv;
      size = 1 << s;
      epb  = (s == 3) ? 0 : 4 / size;
      n    = (v * size + 3) / 4;
      if (n > 16) n = 16;
      if (s == 3 || !m || v == 0) n = 0;
      for (int b = 0; b < n; b++) begin
        e = v - b * epb;
        if (e > epb) e = epb;
        if (w) wq.push_back('{k + 1 + b + L, b % 4, b / 4, e - 1});
      end
      rv = (n == 0) ? k + 1 : k + n + L + 1;
      rq.push_back('{rv, (s == 3) ? 1 : 0});
      next_free = rv + 1;
      $display("L=%0d txn accept cycle %0d vl=%0d vsew=%0d mc=%0d wr=%0d beats=%0d rvalid@%0d",
               L, k, v, s, m, w, n, rv);
    endtask

    // Called on a falling edge: check handshake state, drive one cycle.
    task automatic step(input bit r, input logic [4:0] v, input logic [1:0] s,
                        input bit m, input bit w);
      chk(L, "busy", int'(busy), (pe < next_free) ? 1 : 0);
      chk(L, "apu_gnt", int'(gnt), (pe >= next_free) ? 1 : 0);
      req    = r;
      vl_i   = v;
      vsew_i = s;
      mc     = m;
      vw     = w;
      if (r && pe >= next_free) model_accept(pe, int'(v), int'(s), m, w);
      @(negedge clk);
    endtask

    task automatic idle_step();
      step(1'b0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic send(input logic [4:0] v, input logic [1:0] s, input bit m, input bit w);
      while (pe < next_free) idle_step();
      step(1'b1, v, s, m, w);
    endtask

    task automatic chk_zero(input string name);
      chk(L, name, int'({gnt, rvalid, busy, cc, ro, last, vrw, wcc, wro, etw, err}), 0);
    endtask

    initial begin
      rst = 1'b1; req = 1'b0; mc = 1'b0; vw = 1'b0; vl_i = 5'd0; vsew_i = 2'd0;
      @(negedge clk);
      chk_zero("reset_outputs");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      send(5'd5,  2'd0, 1'b1, 1'b1);
      send(5'd10, 2'd1, 1'b1, 1'b1);
      send(5'd31, 2'd2, 1'b1, 1'b1);
      send(5'd0,  2'd0, 1'b1, 1'b1);
      send(5'd7,  2'd1, 1'b0, 1'b1);
      send(5'd9,  2'd3, 1'b1, 1'b1);
      send(5'd12, 2'd2, 1'b1, 1'b0);
      send(5'd31, 2'd1, 1'b1, 1'b1);

      // Request held high: back-to-back accepts one cycle after each rvalid.
      for (int i = 0; i < 24; i++) step(1'b1, 5'd4, 2'd2, 1'b1, 1'b1);

      // Reset during the third issue beat drops everything still in flight.
      send(5'd16, 2'd2, 1'b1, 1'b1);
      idle_step();
      idle_step();
      #2;
      rst = 1'b1;
      #1;
      chk_zero("async_reset_outputs");
      wq.delete();
      rq.delete();
      next_free = 0;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        chk_zero("held_reset_outputs");
      end
      rst = 1'b0;
      #1;
      chk(L, "gnt_after_reset", int'(gnt), 1);
      @(negedge clk);

      for (int i = 0; i < 400; i++) begin
        step(1'($urandom_range(0, 2) != 0),
             5'($urandom_range(0, 31)),
             ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
             1'($urandom_range(0, 5) != 0),
             1'($urandom_range(0, 4) != 0));
      end
      for (int i = 0; i < 40; i++) idle_step();

      chk(L, "writes_outstanding", wq.size(), 0);
      chk(L, "responses_outstanding", rq.size(), 0);
      done_count++;
    end

    // Scoreboard monitor: every cycle, the write strobe and rvalid must match
    // whether the head of the expected queue is due in this cycle.
    always @(negedge clk) begin
      bit exp_w, exp_r;
      exp_w = (wq.size() > 0) && (wq[0].cyc == pe);
      exp_r = (rq.size() > 0) && (rq[0].cyc == pe);
      chk(L, "vec_reg_write", int'(vrw), exp_w ? 1 : 0);
      if (exp_w) begin
        if (vrw) begin
          chk(L, "wb_cycle_count", int'(wcc), wq[0].cc);
          chk(L, "wb_reg_offset", int'(wro), wq[0].ro);
          chk(L, "elements_to_write", int'(etw), wq[0].etw);
        end
        void'(wq.pop_front());
      end
      chk(L, "apu_rvalid", int'(rvalid), exp_r ? 1 : 0);
      chk(L, "seq_error", int'(err), exp_r ? rq[0].err : 0);
      if (exp_r) void'(rq.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 20000 && done_count < 3; i++) @(posedge clk);
    checks++;
    if (done_count < 3) begin
      errors++;
      $display("FAIL timeout: %0d of 3 drivers finished, required 3", done_count);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
